// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU: IDLE grants, EXEC captures, RESP hands back.
// Optional grant statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [4:0]       req_op0,
  input  logic [4:0]       req_op1,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  output logic [4:0]       alu_op,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  input  logic [31:0]      alu_out,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_gnt;
  logic [4:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic        r_rsp_zero;

  logic        w_win;
  logic [1:0]  w_grant;
  logic        w_rsp_done;

  // On contention the requester that was not granted last wins.
  always_comb begin
    w_win = 1'b0;
    case (req_valid)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  always_comb begin
    w_grant = 2'b00;
    if (rst_n && (r_state == S_IDLE) && (|req_valid)) begin
      w_grant = w_win ? 2'b10 : 2'b01;
    end
  end

  assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_gnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_gnt        <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_gnt   <= w_win;
            r_last  <= w_win;
            r_op    <= w_win ? req_op1 : req_op0;
            r_a     <= w_win ? req_a1 : req_a0;
            r_b     <= w_win ? req_b1 : req_b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_result <= alu_out;
          r_rsp_zero   <= alu_zero;
          r_rsp_valid  <= r_gnt ? 2'b10 : 2'b01;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_done) begin
            r_rsp_valid <= 2'b00;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign alu_op     = r_op;
  assign alu_in1    = r_a;
  assign alu_in2    = r_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_grant_cnt [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant_cnt
      // Saturate at all-ones rather than wrap.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_grant_cnt[gi] <= '0;
        end else if (w_grant[gi] && (r_grant_cnt[gi] != {CNT_W{1'b1}})) begin
          r_grant_cnt[gi] <= r_grant_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign grant_cnt0 = r_grant_cnt[0];
  assign grant_cnt1 = r_grant_cnt[1];
`else
  generate
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
  endgenerate
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU; define ALU_ARB_STATS_EN to also check the counters.
module tb_alu_arbiter;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01111;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [4:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1, alu_in2;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
`ifdef ALU_ARB_STATS_EN
  logic [3:0]  grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;

`ifdef ALU_ARB_STATS_EN
  alu_arbiter #(.CNT_W(4)) dut (
`else
  alu_arbiter dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU stand-in.
  always_comb begin
    case (alu_op)
      OP_AND:  alu_out = alu_in1 & alu_in2;
      OP_OR:   alu_out = alu_in1 | alu_in2;
      OP_ADD:  alu_out = alu_in1 + alu_in2;
      OP_SUB:  alu_out = alu_in1 - alu_in2;
      OP_MUL:  alu_out = alu_in1 * alu_in2;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_op0 = OP_ADD; req_a0 = 32'h11; req_b0 = 32'h22;
    req_op1 = OP_OR;  req_a1 = 32'h33; req_b1 = 32'h44;

    // Reset state: everything zero even with requests pending.
    nclk(); nclk();
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // Single request from requester 0.
    nclk();
    req_valid = 2'b01; req_op0 = OP_MUL; req_a0 = 32'hF; req_b0 = 32'hF;
    #1 chk("t1_req_ready_idle", {30'd0, req_ready}, 32'd1);
    nclk();
    chk("t1_exec_req_ready", {30'd0, req_ready}, 32'd0);
    chk("t1_exec_alu_op", {27'd0, alu_op}, {27'd0, OP_MUL});
    chk("t1_exec_alu_in1", alu_in1, 32'hF);
    chk("t1_exec_alu_in2", alu_in2, 32'hF);
    chk("t1_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b00; req_op0 = OP_ADD; req_a0 = 32'h123;
    nclk();
    chk("t1_resp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t1_resp_result", rsp_result, 32'hE1);
    chk("t1_resp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("t1_resp_alu_op_held", {27'd0, alu_op}, {27'd0, OP_MUL});
    rsp_ready = 2'b01;
    nclk();
    chk("t1_done_valid", {30'd0, rsp_valid}, 32'd0);
    rsp_ready = 2'b00;

    // Contention right after reset: requester 0 first, then requester 1.
    rst_n = 1'b0;
    nclk();
    rst_n = 1'b1;
    req_valid = 2'b11;
    req_op0 = OP_ADD; req_a0 = 32'd1;  req_b0 = 32'd2;
    req_op1 = OP_SUB; req_a1 = 32'd10; req_b1 = 32'd3;
    #1 chk("t2_first_grant", {30'd0, req_ready}, 32'd1);
    nclk();
    chk("t2_exec_req_ready", {30'd0, req_ready}, 32'd0);
    chk("t2_exec_alu_in1", alu_in1, 32'd1);
    nclk();
    chk("t2_r0_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t2_r0_result", rsp_result, 32'd3);
    rsp_ready = 2'b11;
    #1 chk("t2_no_grant_in_handshake", {30'd0, req_ready}, 32'd0);
    nclk();
    rsp_ready = 2'b00;
    #1 chk("t2_second_grant", {30'd0, req_ready}, 32'd2);
    nclk();
    chk("t2_exec_alu_op", {27'd0, alu_op}, {27'd0, OP_SUB});
    req_valid = 2'b00;
    nclk();
    chk("t2_r1_valid", {30'd0, rsp_valid}, 32'd2);
    chk("t2_r1_result", rsp_result, 32'd7);
    rsp_ready = 2'b01;
    nclk();
    chk("t2_wrong_ready_ignored", {30'd0, rsp_valid}, 32'd2);
    rsp_ready = 2'b10;
    nclk();
    chk("t2_r1_done", {30'd0, rsp_valid}, 32'd0);
    rsp_ready = 2'b00;

    // Back-pressure on requester 1 while requester 0 waits.
    req_valid = 2'b10; req_op1 = OP_AND; req_a1 = 32'hF0F0; req_b1 = 32'hFF00;
    #1 chk("t3_grant", {30'd0, req_ready}, 32'd2);
    nclk();
    req_valid = 2'b01; req_op0 = OP_SUB; req_a0 = 32'h5; req_b0 = 32'h5;
    nclk();
    for (int i = 0; i < 5; i++) begin
      chk("t3_bp_valid", {30'd0, rsp_valid}, 32'd2);
      chk("t3_bp_result", rsp_result, 32'hF000);
      #1 chk("t3_bp_req_ready", {30'd0, req_ready}, 32'd0);
      nclk();
    end
    rsp_ready = 2'b10;
    #1 chk("t3_handshake_req_ready", {30'd0, req_ready}, 32'd0);
    nclk();
    rsp_ready = 2'b00;

    // Zero flag via subtract from requester 0.
    #1 chk("t4_grant", {30'd0, req_ready}, 32'd1);
    nclk();
    req_valid = 2'b00;
    nclk();
    chk("t4_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t4_result", rsp_result, 32'd0);
    chk("t4_zero", {31'd0, rsp_zero}, 32'd1);
    rsp_ready = 2'b01;
    nclk();
    rsp_ready = 2'b00;

    // Reset pulsed while a response is pending.
    req_valid = 2'b10; req_op1 = OP_OR; req_a1 = 32'd1; req_b1 = 32'd2;
    nclk();
    req_valid = 2'b00;
    nclk();
    chk("t5_resp_valid", {30'd0, rsp_valid}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {30'd0, rsp_valid}, 32'd0);
    chk("t5_rst_result", rsp_result, 32'd0);
    chk("t5_rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("t5_rst_alu_in1", alu_in1, 32'd0);
    chk("t5_rst_alu_in2", alu_in2, 32'd0);
    nclk();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nclk();
      chk("t5_no_resp_after", {30'd0, rsp_valid}, 32'd0);
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating counters: 20 grants to requester 1 only.
    rst_n = 1'b0;
    nclk();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_valid = 2'b10;
      nclk();
      req_valid = 2'b00;
      nclk();
      rsp_ready = 2'b10;
      nclk();
      rsp_ready = 2'b00;
    end
    chk("t6_grant_cnt1", {28'd0, grant_cnt1}, 32'hF);
    chk("t6_grant_cnt0", {28'd0, grant_cnt0}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
